// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, width limits and the parity helper
// used by both the RX and TX sides.
package uart_pkg;

   localparam int MAX_DATA_W = 9;

   typedef enum logic [2:0] {
      SYNC,
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      ERROR
   } rx_state_t;

   // Parity bit that a transmitter appends to the low 'width' bits of data.
   function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] data,
                                       input int width,
                                       input logic odd);
      logic p;
      p = odd;
      for (int i = 0; i < MAX_DATA_W; i++) begin
         if (i < width) p ^= data[i];
      end
      return p;
   endfunction

   function automatic int mid_tick(input int oversample);
      return oversample / 2 - 1;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit tick counter and bit decision strobe for the UART receiver.
// UART_RX_MAJORITY_EN selects a 2-of-3 vote around mid-bit instead of a single sample.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int P_OVERSAMPLE = 16
)
(
   input  logic CLK,
   input  logic reset_n,
   input  logic serial_in,
   input  logic baud_tick,
   input  logic cnt_clr,
   output logic line_s,
   output logic bit_stb,
   output logic bit_val
);

   localparam int CNT_W = $clog2(P_OVERSAMPLE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(mid_tick(P_OVERSAMPLE));
   localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(mid_tick(P_OVERSAMPLE) + 1);

   logic             sync_1;
   logic [CNT_W-1:0] tick_cnt;
   logic             s_mid;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         sync_1 <= 1'b1;
         line_s <= 1'b1;
      end else begin
         sync_1 <= serial_in;
         line_s <= sync_1;
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt <= '0;
      end else if (cnt_clr) begin
         tick_cnt <= '0;
      end else if (baud_tick) begin
         tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + 1'b1;
      end
   end

   // The decision is always made one tick after mid so both sampling modes share latency.
   assign bit_stb = baud_tick && !cnt_clr && (tick_cnt == CNT_DEC);

`ifdef UART_RX_MAJORITY_EN
   localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(mid_tick(P_OVERSAMPLE) - 1);

   logic s_early;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         s_early <= 1'b0;
         s_mid   <= 1'b0;
      end else if (baud_tick) begin
         if (tick_cnt == CNT_EARLY) s_early <= line_s;
         if (tick_cnt == CNT_MID)   s_mid   <= line_s;
      end
   end

   assign bit_val = (s_early & s_mid) | (s_early & line_s) | (s_mid & line_s);
`else
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         s_mid <= 1'b0;
      end else if (baud_tick && (tick_cnt == CNT_MID)) begin
         s_mid <= line_s;
      end
   end

   assign bit_val = s_mid;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: idle qualification, framing/parity checks, one-entry
// ready/valid holding register and sticky error flags. Optional macro: UART_RX_MAJORITY_EN.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int P_DATA_W      = 8,
   parameter int P_OVERSAMPLE  = 16,
   parameter int P_REG_MODE_TH = 160
)
(
   input  logic                CLK,
   input  logic                reset_n,
   input  logic                serial_in,
   input  logic                baud_tick,
   input  logic                parity_en,
   input  logic                parity_odd,
   input  logic                two_stop,
   input  logic                err_clr,
   output logic [P_DATA_W-1:0] Do,
   output logic                valid,
   input  logic                ready,
   output logic                frame_err,
   output logic                parity_err,
   output logic                overrun,
   output logic                busy
);

   localparam int SYNC_W = $clog2(P_REG_MODE_TH + 1);
   localparam int BIT_W  = $clog2(P_DATA_W);
   localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(P_REG_MODE_TH - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(P_DATA_W - 1);

   rx_state_t state_q, state_d;

   logic                line_s, bit_stb, bit_val;
   logic [SYNC_W-1:0]   sync_cnt;
   logic [BIT_W-1:0]    bit_cnt;
   logic                stop_idx;
   logic [P_DATA_W-1:0] shift_q;
   logic                cfg_parity_en, cfg_parity_odd, cfg_two_stop;
   logic                par_bad, par_mismatch;
   logic                start_det, shift_en, par_sample, stop_next, load_req, set_frame_err;

   assign busy = (state_q == START) || (state_q == DATA) ||
                 (state_q == PARITY) || (state_q == STOP);

   uart_rx_sampler #(
      .P_OVERSAMPLE (P_OVERSAMPLE)
   ) u_sampler (
      .CLK       (CLK),
      .reset_n   (reset_n),
      .serial_in (serial_in),
      .baud_tick (baud_tick),
      .cnt_clr   (!busy),
      .line_s    (line_s),
      .bit_stb   (bit_stb),
      .bit_val   (bit_val)
   );

   assign par_mismatch = bit_val != parity_bit(MAX_DATA_W'(shift_q), P_DATA_W, cfg_parity_odd);

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) state_q <= SYNC;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      start_det     = 1'b0;
      shift_en      = 1'b0;
      par_sample    = 1'b0;
      stop_next     = 1'b0;
      load_req      = 1'b0;
      set_frame_err = 1'b0;
      unique case (state_q)
         SYNC: begin
            if (baud_tick && line_s && (sync_cnt == SYNC_LAST)) state_d = IDLE;
         end
         IDLE: begin
            if (baud_tick && !line_s) begin
               state_d   = START;
               start_det = 1'b1;
            end
         end
         START: begin
            if (bit_stb) begin
               if (bit_val) begin
                  state_d       = ERROR;
                  set_frame_err = 1'b1;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (bit_stb) begin
               shift_en = 1'b1;
               if (bit_cnt == BIT_LAST) state_d = cfg_parity_en ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_stb) begin
               par_sample = 1'b1;
               state_d    = STOP;
            end
         end
         STOP: begin
            if (bit_stb) begin
               if (!bit_val) begin
                  state_d       = ERROR;
                  set_frame_err = 1'b1;
               end else if (cfg_two_stop && !stop_idx) begin
                  stop_next = 1'b1;
               end else begin
                  state_d  = IDLE;
                  load_req = !par_bad;
               end
            end
         end
         ERROR: begin
            if (err_clr) state_d = SYNC;
         end
         default: state_d = SYNC;
      endcase
   end

   // Frame datapath: idle qualifier, per-frame configuration snapshot and shift register.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         sync_cnt       <= '0;
         bit_cnt        <= '0;
         stop_idx       <= 1'b0;
         shift_q        <= '0;
         cfg_parity_en  <= 1'b0;
         cfg_parity_odd <= 1'b0;
         cfg_two_stop   <= 1'b0;
         par_bad        <= 1'b0;
      end else begin
         if (state_q != SYNC || !line_s) sync_cnt <= '0;
         else if (baud_tick)             sync_cnt <= sync_cnt + 1'b1;
         if (start_det) begin
            cfg_parity_en  <= parity_en;
            cfg_parity_odd <= parity_odd;
            cfg_two_stop   <= two_stop;
            bit_cnt        <= '0;
            stop_idx       <= 1'b0;
            par_bad        <= 1'b0;
         end
         if (shift_en) begin
            shift_q <= {bit_val, shift_q[P_DATA_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (par_sample && par_mismatch) par_bad  <= 1'b1;
         if (stop_next)                  stop_idx <= 1'b1;
      end
   end

   // Holding register and sticky flags; a set in the same cycle as err_clr wins.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         Do         <= '0;
         valid      <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (load_req && (!valid || ready)) begin
            Do    <= shift_q;
            valid <= 1'b1;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
         if (err_clr) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
         end
         if (set_frame_err)                  frame_err  <= 1'b1;
         if (par_sample && par_mismatch)     parity_err <= 1'b1;
         if (load_req && valid && !ready)    overrun    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed scoreboard bench for uart_rx_param: an 8-bit instance and a 7-bit instance
// driven by a bit-level serial frame generator; UART_RX_MAJORITY_EN adds a glitch step.
module tb_uart_rx_param;
   import uart_pkg::*;

   logic       CLK = 1'b0;
   logic       reset_n = 1'b0;
   logic       baud_tick = 1'b0;
   logic       line8 = 1'b0, line7 = 1'b0;
   logic       parity_en = 1'b0, parity_odd = 1'b0, two_stop = 1'b0, err_clr = 1'b0;
   logic       ready8 = 1'b0, ready7 = 1'b0;
   logic [7:0] Do8;
   logic [6:0] Do7;
   logic       valid8, frame_err8, parity_err8, overrun8, busy8;
   logic       valid7, frame_err7, parity_err7, overrun7, busy7;

   int         n_checks = 0;
   int         n_fail = 0;
   int         div = 0;
   logic [7:0] q8[$];
   logic [6:0] q7[$];
   logic [7:0] exp8;
   logic [6:0] exp7;
   logic [6:0] word7;

   uart_rx_param #(.P_DATA_W(8), .P_OVERSAMPLE(16), .P_REG_MODE_TH(160)) dut8 (
      .CLK(CLK), .reset_n(reset_n), .serial_in(line8), .baud_tick(baud_tick),
      .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop), .err_clr(err_clr),
      .Do(Do8), .valid(valid8), .ready(ready8), .frame_err(frame_err8),
      .parity_err(parity_err8), .overrun(overrun8), .busy(busy8));

   uart_rx_param #(.P_DATA_W(7), .P_OVERSAMPLE(16), .P_REG_MODE_TH(160)) dut7 (
      .CLK(CLK), .reset_n(reset_n), .serial_in(line7), .baud_tick(baud_tick),
      .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop), .err_clr(err_clr),
      .Do(Do7), .valid(valid7), .ready(ready7), .frame_err(frame_err7),
      .parity_err(parity_err7), .overrun(overrun7), .busy(busy7));

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (div == 8) begin
         div = 0;
         baud_tick = 1'b1;
      end else begin
         div++;
         baud_tick = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         while (!baud_tick) @(posedge CLK);
      end
   endtask

   task automatic set_line(input bit to7, input logic v);
      #1;
      if (to7) line7 = v;
      else     line8 = v;
   endtask

   task automatic drive_bit(input bit to7, input logic v, input bit glitch);
      set_line(to7, v);
      if (glitch) begin
         wait_ticks(8);
         set_line(to7, !v);
         wait_ticks(1);
         set_line(to7, v);
         wait_ticks(7);
      end else begin
         wait_ticks(16);
      end
   endtask

   task automatic send_frame(input bit to7, input logic [8:0] data, input int nbits,
                             input bit par_on, input logic par_val, input logic last_stop,
                             input int nstop, input int glitch_bit);
      drive_bit(to7, 1'b0, 1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(to7, data[i], i == glitch_bit);
      if (par_on) drive_bit(to7, par_val, 1'b0);
      for (int s = 0; s < nstop; s++) drive_bit(to7, (s == nstop - 1) ? last_stop : 1'b1, 1'b0);
      set_line(to7, 1'b1);
   endtask

   task automatic pulse_err_clr();
      @(posedge CLK); #1 err_clr = 1'b1;
      @(posedge CLK); #1 err_clr = 1'b0;
   endtask

   task automatic pulse_ready8();
      @(posedge CLK); #1 ready8 = 1'b1;
      @(posedge CLK); #1 ready8 = 1'b0;
   endtask

   function automatic logic model_parity(input logic [7:0] d, input logic odd);
      return odd ? ~(^d) : (^d);
   endfunction

   always @(negedge CLK) begin
      if (reset_n && valid7 && ready7) begin
         if (q7.size() == 0) begin
            check("sb7_unexpected_word", 16'(q7.size()), 16'd1);
         end else begin
            exp7 = q7.pop_front();
            check("sb7_word", 16'(Do7), 16'(exp7));
         end
      end
   end

   initial begin
      // Reset with the line held low
      #23;
      check("rst_valid", 16'(valid8), 16'd0);
      check("rst_do", 16'(Do8), 16'd0);
      check("rst_frame_err", 16'(frame_err8), 16'd0);
      check("rst_busy", 16'(busy8), 16'd0);
      check("rst_state", 16'(dut8.state_q), 16'(SYNC));
      reset_n = 1'b1;
      wait_ticks(5);
      set_line(1'b0, 1'b1);
      set_line(1'b1, 1'b1);
      wait_ticks(150);
      check("sync_not_yet_idle", 16'(dut8.state_q), 16'(SYNC));
      wait_ticks(50);
      check("sync_idle", 16'(dut8.state_q), 16'(IDLE));
      check("sync_idle7", 16'(dut7.state_q), 16'(IDLE));
      check("sync_no_valid", 16'(valid8), 16'd0);

      // One-tick low pulse: false start
      set_line(1'b0, 1'b0);
      wait_ticks(1);
      set_line(1'b0, 1'b1);
      wait_ticks(3);
      check("false_start_busy", 16'(busy8), 16'd1);
      wait_ticks(12);
      check("false_start_frame_err", 16'(frame_err8), 16'd1);
      check("false_start_state", 16'(dut8.state_q), 16'(ERROR));
      check("false_start_busy_off", 16'(busy8), 16'd0);
      pulse_err_clr();
      check("err_clr_frame_err", 16'(frame_err8), 16'd0);
      check("err_clr_requalify", 16'(dut8.state_q), 16'(SYNC));
      wait_ticks(170);
      check("requalified_idle", 16'(dut8.state_q), 16'(IDLE));

      // 0x55 8N1 with a low stop bit
      send_frame(1'b0, 9'h055, 8, 1'b0, 1'b0, 1'b0, 1, -1);
      check("bad_stop_frame_err", 16'(frame_err8), 16'd1);
      check("bad_stop_no_valid", 16'(valid8), 16'd0);
      check("bad_stop_state", 16'(dut8.state_q), 16'(ERROR));
      pulse_err_clr();
      wait_ticks(170);
      check("bad_stop_requalified", 16'(dut8.state_q), 16'(IDLE));

      // 0xA3 with odd parity: correct, then wrong parity bit
      parity_en = 1'b1;
      parity_odd = 1'b1;
      q8.push_back(8'hA3);
      send_frame(1'b0, 9'h0A3, 8, 1'b1, model_parity(8'hA3, 1'b1), 1'b1, 1, -1);
      check("par_ok_valid", 16'(valid8), 16'd1);
      exp8 = q8.pop_front();
      check("par_ok_do", 16'(Do8), 16'(exp8));
      check("par_ok_no_err", 16'(parity_err8), 16'd0);
      pulse_ready8();
      check("par_ok_consumed", 16'(valid8), 16'd0);
      send_frame(1'b0, 9'h0A3, 8, 1'b1, ~model_parity(8'hA3, 1'b1), 1'b1, 1, -1);
      check("par_bad_flag", 16'(parity_err8), 16'd1);
      check("par_bad_no_valid", 16'(valid8), 16'd0);
      check("par_bad_no_frame_err", 16'(frame_err8), 16'd0);
      check("par_bad_state", 16'(dut8.state_q), 16'(IDLE));
      pulse_err_clr();
      check("par_clr_flag", 16'(parity_err8), 16'd0);
      check("par_clr_state", 16'(dut8.state_q), 16'(IDLE));
      parity_en = 1'b0;
      parity_odd = 1'b0;

      // Overrun: two frames with ready held low
      q8.push_back(8'h12);
      send_frame(1'b0, 9'h012, 8, 1'b0, 1'b0, 1'b1, 1, -1);
      send_frame(1'b0, 9'h034, 8, 1'b0, 1'b0, 1'b1, 1, -1);
      check("ovr_valid", 16'(valid8), 16'd1);
      exp8 = q8.pop_front();
      check("ovr_do_kept", 16'(Do8), 16'(exp8));
      check("ovr_flag", 16'(overrun8), 16'd1);
      pulse_ready8();
      check("ovr_consumed", 16'(valid8), 16'd0);
      pulse_err_clr();
      check("ovr_clr", 16'(overrun8), 16'd0);

      // 7-bit instance, two stop bits, back-to-back random words
      two_stop = 1'b1;
      ready7 = 1'b1;
      for (int k = 0; k < 10; k++) begin
         word7 = 7'($urandom_range(0, 127));
         q7.push_back(word7);
         send_frame(1'b1, {2'b00, word7}, 7, 1'b0, 1'b0, 1'b1, 2, -1);
      end
      wait_ticks(30);
      check("w7_all_received", 16'(q7.size()), 16'd0);
      check("w7_frame_err", 16'(frame_err7), 16'd0);
      check("w7_parity_err", 16'(parity_err7), 16'd0);
      check("w7_overrun", 16'(overrun7), 16'd0);
      two_stop = 1'b0;
      ready7 = 1'b0;

`ifdef UART_RX_MAJORITY_EN
      // Single-tick glitch at mid of data bit 3 is outvoted
      q8.push_back(8'h5A);
      send_frame(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 1, 3);
      check("vote_valid", 16'(valid8), 16'd1);
      exp8 = q8.pop_front();
      check("vote_do", 16'(Do8), 16'(exp8));
      pulse_ready8();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
